// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_buffer
//  Brief    : Fetch-to-decode decoupling queue. Holds {pc, instr} pairs in
//             strict FIFO order and hands them to decode through a
//             valid/ready handshake. It back-pressures fetch when full and
//             drops every entry on a flush.
//  Revision : 1.0 - initial release
// ============================================================================
module if_id_buffer #(
    parameter int          DEPTH     = 2,
    parameter int          PC_W      = 64,
    parameter int          INSTR_W   = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [PC_W-1:0]            out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [PC_W-1:0]    r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Handshake decode: readiness depends on occupancy only, so decode's
    // out_ready never reaches fetch combinationally.
    always_comb begin
        in_ready  = (r_count != c_FULL);
        out_valid = (r_count != '0);
        w_push    = in_valid && in_ready;
        w_pop     = out_valid && out_ready;
    end

    // Head presentation: a NOP bubble with pc 0 is shown while empty.
    always_comb begin
        out_pc    = '0;
        out_instr = INSTR_W'(NOP_INSTR);
        if (out_valid) begin
            out_pc    = r_pc_mem[r_rd_ptr];
            out_instr = r_instr_mem[r_rd_ptr];
        end
    end

    // Entry storage: written on every accepted push; never cleared because
    // the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_instr_mem[r_wr_ptr] <= in_instr;
        end
    end

    // Pointer/occupancy state: reset beats flush, flush beats push/pop.
    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_buffer
//  Brief    : Self-checking bench for if_id_buffer. A queue-based reference
//             model is compared against the DUT on every falling edge, and
//             directed literal checks pin the model's behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

    localparam int c_DEPTH   = 2;
    localparam int c_PC_W    = 64;
    localparam int c_INSTR_W = 32;
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic [c_PC_W-1:0]    in_pc;
    logic [c_INSTR_W-1:0] in_instr;
    logic                 in_ready;
    logic                 out_valid;
    logic [c_PC_W-1:0]    out_pc;
    logic [c_INSTR_W-1:0] out_instr;
    logic                 out_ready;
    logic                 flush;
    logic [1:0]           count;

    int total = 0;
    int bad   = 0;
    bit r_checking = 1'b0;

    if_id_buffer #(
        .DEPTH(c_DEPTH), .PC_W(c_PC_W), .INSTR_W(c_INSTR_W), .NOP_INSTR(c_NOP)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: plain queue of {pc, instr} following the buffer rules.
    typedef struct packed {
        logic [c_PC_W-1:0]    pc;
        logic [c_INSTR_W-1:0] instr;
    } entry_t;

    entry_t model_q[$];

    always @(posedge clk) begin
        automatic bit do_pop;
        automatic bit do_push;
        if (!reset || flush) begin
            model_q.delete();
        end else begin
            do_pop  = (model_q.size() != 0) && out_ready;
            do_push = in_valid && (model_q.size() != c_DEPTH);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back('{pc: in_pc, instr: in_instr});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on the falling edge.
    always @(negedge clk) begin
        if (r_checking) begin
            chk("m_in_ready",  64'(in_ready),  64'(model_q.size() != c_DEPTH));
            chk("m_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
            chk("m_count",     64'(count),     64'(model_q.size()));
            if (model_q.size() != 0) begin
                chk("m_out_pc",    out_pc,          model_q[0].pc);
                chk("m_out_instr", 64'(out_instr),  64'(model_q[0].instr));
            end else begin
                chk("m_out_pc",    out_pc,          64'h0);
                chk("m_out_instr", 64'(out_instr),  64'(c_NOP));
            end
        end
    end

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return 32'hA000_0093 ^ pc[31:0];
    endfunction

    // Advance one cycle; inputs change only after the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [63:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_instr = instr_of(pc);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        out_ready = 1'b0; flush = 1'b0;
        repeat (2) tick();
        r_checking = 1'b1;
        reset = 1'b1;
        tick();

        // Reset then idle
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'h13);
        chk("rst_out_pc",    out_pc,         64'h0);
        chk("rst_count",     64'(count),     64'd0);

        // Single pass
        in_valid = 1'b1; in_pc = 64'h0; in_instr = 32'h0031_00B3;
        tick();
        in_valid = 1'b0;
        chk("sp_out_valid", 64'(out_valid), 64'd1);
        chk("sp_out_instr", 64'(out_instr), 64'h0031_00B3);
        chk("sp_count",     64'(count),     64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("sp_drain_valid", 64'(out_valid), 64'd0);
        chk("sp_drain_count", 64'(count),     64'd0);

        // Fill and back-pressure
        drive(1'b1, 64'h0); tick();
        drive(1'b1, 64'h4); tick();
        chk("full_count",    64'(count),    64'd2);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 64'h8);
        repeat (3) tick();
        chk("hold_count",  64'(count), 64'd2);
        chk("hold_out_pc", out_pc,     64'h0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("pop1_in_ready", 64'(in_ready), 64'd1);
        chk("pop1_out_pc",   out_pc,        64'h4);
        chk("pop1_count",    64'(count),    64'd1);
        tick();
        drive(1'b0, 64'h0);
        chk("acc8_count", 64'(count), 64'd2);
        out_ready = 1'b1;
        tick();
        chk("pop2_out_pc", out_pc, 64'h8);
        tick();
        chk("pop3_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Streaming with wrap
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 64'(i * 4));
            tick();
            chk("stream_out_pc", out_pc,     64'(i * 4));
            chk("stream_count",  64'(count), 64'd1);
        end
        drive(1'b0, 64'h0);
        tick();
        chk("stream_end_count", 64'(count), 64'd0);
        out_ready = 1'b0;

        // Flush with simultaneous push/pop
        drive(1'b1, 64'h10); tick();
        drive(1'b1, 64'h14); tick();
        chk("pre_flush_count", 64'(count), 64'd2);
        drive(1'b1, 64'h18); out_ready = 1'b1; flush = 1'b1;
        tick();
        drive(1'b0, 64'h0); out_ready = 1'b0; flush = 1'b0;
        chk("flush_count",     64'(count),     64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready",  64'(in_ready),  64'd1);
        drive(1'b1, 64'h40); tick();
        chk("post_flush_pc", out_pc, 64'h40);

        // Reset mid-stream
        drive(1'b1, 64'h44); tick();
        chk("pre_rst_count", 64'(count), 64'd2);
        drive(1'b1, 64'h48); reset = 1'b0;
        tick();
        reset = 1'b1; drive(1'b0, 64'h0);
        chk("mrst_count",     64'(count),     64'd0);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_out_instr", 64'(out_instr), 64'h13);
        tick();
        chk("mrst_no_retain", 64'(out_valid), 64'd0);

        r_checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Decoupling queue between the fetch stage (PC plus instruction memory) and the decode stage.
- Captures each fetched {pc, instruction} pair and presents entries to decode in order through a valid/ready handshake.
- Back-pressures fetch so the PC holds, and discards all entries on a control-flow flush.
- Sits directly downstream of fetch and directly upstream of decode.

Parameters:
DEPTH, 2, number of entries; power of 2, minimum 2
PC_W, 64, PC width
INSTR_W, 32, instruction width
NOP_INSTR, 32'h00000013, instruction presented when empty (addi x0,x0,0)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset; sampled on the rising clk edge, state cleared when 0
in_valid  input  1  fetch presents a valid pc/instruction this cycle
in_pc  input  PC_W  PC of the fetched instruction
in_instr  input  INSTR_W  fetched instruction word
in_ready  output  1  buffer can accept; fetch holds the PC when 0
out_valid  output  1  head entry valid for decode
out_pc  output  PC_W  PC of the head entry
out_instr  output  INSTR_W  instruction of the head entry
out_ready  input  1  decode consumes the head this cycle
flush  input  1  discard all entries (branch taken / redirect)
count  output  clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: DEPTH entries of {pc, instr}. Write pointer, read pointer and count are registered. Pointers wrap modulo DEPTH.
- Push: in_valid && in_ready at the rising edge. Writes the entry at wr_ptr, then wr_ptr+1.
- Pop: out_valid && out_ready at the rising edge. Advances rd_ptr.
- in_ready = (count != DEPTH). Combinational from count only; never depends on out_ready, so there is no ready path from decode to fetch.
- out_valid = (count != 0).
- out_pc and out_instr are driven from the head entry when out_valid. When empty, out_pc = 0 and out_instr = NOP_INSTR.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Full (count == DEPTH): in_ready = 0. in_valid is ignored, and fetch must keep in_pc/in_instr stable. A pop in the same cycle frees a slot; in_ready rises the next cycle.
- Empty (count == 0): no pop occurs regardless of out_ready. A push becomes visible on out_* one cycle later (latency 1, no bypass).
- Flush has priority over push and pop. At the edge where flush = 1:
  - count, wr_ptr and rd_ptr go to 0.
  - Any simultaneous push is discarded.
  - Next cycle: out_valid = 0 and in_ready = 1.
- Reset (reset == 0 at the edge) has priority over flush and takes the same actions. Entry contents need not be cleared.
- Reset values: in_ready 1, out_valid 0, out_pc 0, out_instr NOP_INSTR, count 0. Reset asserted mid-stream drops all in-flight entries.
- Ordering: strict FIFO. No entry is duplicated or skipped across pointer wrap.
- Throughput: with out_ready held at 1 and in_valid held at 1, one entry per cycle in steady state.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then 1 with no traffic -> in_ready=1, out_valid=0, out_instr=0x00000013, out_pc=0, count=0.
- Single pass: push pc=0x0, instr=0x003100B3 with out_ready=0 -> next cycle out_valid=1, out_pc=0x0, out_instr=0x003100B3, count=1. Assert out_ready=1 for one cycle -> out_valid=0, count=0.
- Fill and back-pressure: push pc 0x0 and 0x4 with out_ready=0 -> count=2, in_ready=0. Hold in_valid=1 with pc=0x8 for 3 cycles -> no change. Pop once -> in_ready=1 next cycle, then 0x8 is accepted. Pops yield 0x4, then 0x8.
- Streaming with wrap: in_valid=1 and out_ready=1 continuously, pcs 0x0 through 0x18 stepping by 4 -> out_pc sequence 0x0, 0x4, ..., 0x18 with no gaps after the first cycle, count stays 1, pointers wrap at least 3 times.
- Flush with simultaneous push/pop: count=2 holding pc 0x10 and 0x14. Assert flush together with in_valid (pc=0x18) and out_ready -> next cycle count=0, out_valid=0, in_ready=1. Subsequent push of pc=0x40 appears as head.
- Reset mid-stream: count=2, then reset=0 for one edge while in_valid=1 -> count=0, out_valid=0, out_instr=0x00000013. Pushed entry not retained.
